// File: rtl/apb_vec_mac.sv
// -----------------------------------------------------------------------------
// apb_vec_mac : APB-attached vector multiply/accumulate engine.
//
// Holds two operand banks (A, B) of N_ELEM unsigned DATA_WIDTH-bit elements,
// packed 32/DATA_WIDTH elements per APB word. A START write runs a sequential
// engine doing one multiply per cycle. MODE 0 stores per-element products in
// the result bank; MODE 1 accumulates them into a dot-product accumulator.
//
// Ports:
//   HCLK     in   clock, all state on rising edge
//   HRESET   in   asynchronous active-high reset
//   PADDR    in   APB address (byte offset, 4 KB window)
//   PWDATA   in   APB write data
//   PWRITE   in   APB write strobe
//   PSEL     in   APB slave select
//   PENABLE  in   APB access phase
//   PRDATA   out  read data, combinational from registers and PADDR
//   PREADY   out  tied 1 (no wait states)
//   PSLVERR  out  set for writes rejected while the engine is busy
//   irq_o    out  (only with ACC_IRQ_EN) registered DONE & IRQ_EN
//
// Optional feature macro: ACC_IRQ_EN (adds the irq_o output).
// -----------------------------------------------------------------------------
module apb_vec_mac #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_ELEM         = 9,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR
`ifdef ACC_IRQ_EN
    ,
    output logic                      irq_o
`endif
);

    localparam int E     = 32 / DATA_WIDTH;             // elements per word
    localparam int PW    = 2 * DATA_WIDTH;              // product width
    localparam int ACC_W = PW + $clog2(N_ELEM);
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    // ------------------------------------------------------------------ state
    logic [DATA_WIDTH-1:0] a_q   [N_ELEM];
    logic [DATA_WIDTH-1:0] b_q   [N_ELEM];
    logic [PW-1:0]         res_q [N_ELEM];

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             done_q, done_d;
    logic             mode_q, mode_d;
    logic             irq_en_q, irq_en_d;

    // ----------------------------------------------------------------- decode
    // Offsets 0x000-0x3FF split into four 256-byte regions by PADDR[11:8]:
    // control/status, bank A, bank B, results. Region word index is PADDR[7:2].
    logic [3:0] region;
    logic [5:0] widx;
    logic       wr, busy;
    logic       sel_ctrl, sel_stat, sel_a, sel_b;

    assign region   = PADDR[11:8];
    assign widx     = PADDR[7:2];
    assign wr       = PSEL & PENABLE & PWRITE;
    assign busy     = (state_q != S_IDLE);
    assign sel_ctrl = (region == 4'd0) && (widx == 6'd0);
    assign sel_stat = (region == 4'd0) && (widx == 6'd1);
    assign sel_a    = (region == 4'd1);
    assign sel_b    = (region == 4'd2);

    logic unused_addr;
    assign unused_addr = ^PADDR[1:0];

    if (APB_ADDR_WIDTH > 12) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^PADDR[APB_ADDR_WIDTH-1:12];
    end

    assign PREADY  = 1'b1;
    // Bank and CTRL writes are locked out while running; STATUS W1C is not.
    assign PSLVERR = wr & busy & (sel_ctrl | sel_a | sel_b);

    // -------------------------------------------------------------- datapath
    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic [PW-1:0]         prod;

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (int'(idx_q) == i) begin
                op_a = a_q[i];
                op_b = b_q[i];
            end
        end
    end

    assign prod = PW'(op_a) * PW'(op_b);

    // ------------------------------------------------------------ control FSM
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        done_d   = done_q;
        mode_d   = mode_q;
        irq_en_d = irq_en_q;

        // W1C first so that the FINISH set below overrides it.
        if (wr && sel_stat && PWDATA[1]) done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr && sel_ctrl) begin
                    mode_d   = PWDATA[1];
                    irq_en_d = PWDATA[2];
                    if (PWDATA[0]) begin
                        done_d  = 1'b0;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (mode_q) acc_d = acc_q + ACC_W'(prod);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N_ELEM - 1)) begin
                    idx_d   = '0;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            mode_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            irq_en_q <= irq_en_d;
        end
    end

    // ------------------------------------------------------- banks / results
    // Elements past N_ELEM in the last word simply have no storage, so writes
    // to those lanes drop and reads return zero.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < N_ELEM; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ELEM; i++) begin
                if (wr && !busy && sel_a && int'(widx) == i / E)
                    a_q[i] <= PWDATA[(i % E) * DATA_WIDTH +: DATA_WIDTH];
                if (wr && !busy && sel_b && int'(widx) == i / E)
                    b_q[i] <= PWDATA[(i % E) * DATA_WIDTH +: DATA_WIDTH];
                if (state_q == S_RUN && !mode_q && int'(idx_q) == i)
                    res_q[i] <= prod;
            end
        end
    end

    // --------------------------------------------------------------- readback
    logic [63:0] acc_ext;
    assign acc_ext = 64'(acc_q);

    always_comb begin
        PRDATA = '1;
        case (region)
            4'd0: begin
                case (widx)
                    6'd0:    PRDATA = {29'b0, irq_en_q, mode_q, 1'b0};
                    6'd1:    PRDATA = {30'b0, done_q, busy};
                    6'd2:    PRDATA = acc_ext[31:0];
                    6'd3:    PRDATA = acc_ext[63:32];
                    default: PRDATA = '1;
                endcase
            end
            4'd1, 4'd2: begin
                PRDATA = '0;
                for (int i = 0; i < N_ELEM; i++) begin
                    if (int'(widx) == i / E)
                        PRDATA[(i % E) * DATA_WIDTH +: DATA_WIDTH] =
                            (region == 4'd1) ? a_q[i] : b_q[i];
                end
            end
            4'd3: begin
                PRDATA = '0;
                for (int i = 0; i < N_ELEM; i++) begin
                    if (int'(widx) == i) PRDATA = 32'(res_q[i]);
                end
            end
            default: PRDATA = '1;
        endcase
    end

`ifdef ACC_IRQ_EN
    logic irq_q;
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) irq_q <= 1'b0;
        else        irq_q <= done_q & irq_en_q;
    end
    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_apb_vec_mac.sv
// -----------------------------------------------------------------------------
// tb_apb_vec_mac : directed + randomized bench for apb_vec_mac (defaults:
// N_ELEM=9, DATA_WIDTH=8). Expected values come from a plain-arithmetic model
// of the banks, result array and dot product.
// -----------------------------------------------------------------------------
module tb_apb_vec_mac;

    localparam int N  = 9;
    localparam int DW = 8;
    localparam int E  = 32 / DW;
    localparam int NW = (N + E - 1) / E;

    logic        HCLK    = 1'b0;
    logic        HRESET  = 1'b1;
    logic [11:0] PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic        PWRITE  = 1'b0;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
`ifdef ACC_IRQ_EN
    logic        irq_o;
`endif

    apb_vec_mac #(.APB_ADDR_WIDTH(12), .N_ELEM(N), .DATA_WIDTH(DW)) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
`ifdef ACC_IRQ_EN
        ,
        .irq_o   (irq_o)
`endif
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int unsigned     ma   [N];
    int unsigned     mb   [N];
    int unsigned     mres [N];
    longint unsigned mdot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apb_wr(input logic [11:0] addr, input logic [31:0] data, output logic err);
        @(negedge HCLK);
        PADDR = addr; PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge HCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] addr, output logic [31:0] data);
        @(negedge HCLK);
        PADDR = addr; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1 data = PRDATA;
        @(posedge HCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    function automatic logic [31:0] pack(input bit is_b, input int w);
        logic [31:0] r;
        int          i;
        r = '0;
        for (int k = 0; k < E; k++) begin
            i = w * E + k;
            if (i < N) r = r | (32'(is_b ? mb[i] : ma[i]) << (DW * k));
        end
        return r;
    endfunction

    task automatic load_banks();
        logic e;
        for (int w = 0; w < NW; w++) begin
            apb_wr(12'(12'h100 + 4 * w), pack(1'b0, w), e);
            apb_wr(12'(12'h200 + 4 * w), pack(1'b1, w), e);
        end
    endtask

    // Model of one complete run: START clears the accumulator.
    task automatic model_run(input bit mode);
        mdot = 0;
        for (int i = 0; i < N; i++) begin
            if (mode) mdot += longint'(ma[i]) * longint'(mb[i]);
            else      mres[i] = ma[i] * mb[i];
        end
    endtask

    // Holds a read of STATUS and counts cycles with BUSY high (bounded).
    task automatic wait_idle(output int cyc);
        cyc = 0;
        PADDR = 12'h004; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge HCLK);
            if (PRDATA[0] !== 1'b1) break;
            cyc++;
        end
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic run(input bit mode, input bit ie, input string tag);
        logic e;
        int   cyc;
        apb_wr(12'h000, {29'b0, ie, mode, 1'b1}, e);
        chk({tag, "_start_err"}, 32'(e), 32'd0);
        model_run(mode);
        wait_idle(cyc);
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'(N + 1));
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] d;
        apb_rd(12'h004, d);
        chk({tag, "_status"}, d, 32'h2);
        for (int i = 0; i < N; i++) begin
            apb_rd(12'(12'h300 + 4 * i), d);
            chk($sformatf("%s_res%0d", tag, i), d, mres[i]);
        end
        apb_rd(12'h008, d);
        chk({tag, "_dot_lo"}, d, mdot[31:0]);
        apb_rd(12'h00C, d);
        chk({tag, "_dot_hi"}, d, mdot[63:32]);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] d;
        logic        e;
        bit          m;

        foreach (ma[i]) begin ma[i] = 0; mb[i] = 0; mres[i] = 0; end
        mdot = 0;

        // ---------------- reset state
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        chk("pready", 32'(PREADY), 32'd1);
        apb_rd(12'h004, d); chk("rst_status", d, 32'h0);
        apb_rd(12'h000, d); chk("rst_ctrl",   d, 32'h0);
        apb_rd(12'h008, d); chk("rst_dot_lo", d, 32'h0);
        apb_rd(12'h300, d); chk("rst_res0",   d, 32'h0);
        apb_rd(12'h100, d); chk("rst_bank_a", d, 32'h0);

        // CTRL write without START only updates MODE
        apb_wr(12'h000, 32'h2, e);
        apb_rd(12'h000, d); chk("ctrl_mode_only", d, 32'h2);
        apb_rd(12'h004, d); chk("ctrl_no_start",  d, 32'h0);

        // ---------------- A = 1..9, B = 2, element-wise
        for (int i = 0; i < N; i++) begin ma[i] = i + 1; mb[i] = 2; end
        load_banks();
        for (int w = 0; w < NW; w++) begin
            apb_rd(12'(12'h100 + 4 * w), d); chk($sformatf("bank_a_w%0d", w), d, pack(1'b0, w));
            apb_rd(12'(12'h200 + 4 * w), d); chk($sformatf("bank_b_w%0d", w), d, pack(1'b1, w));
        end
        run(1'b0, 1'b0, "ew_seq");
        check_outputs("ew_seq");
        apb_rd(12'h300, d); chk("ew_res0_lit", d, 32'd2);
        apb_rd(12'h320, d); chk("ew_res8_lit", d, 32'd18);

        // W1C clears DONE
        apb_wr(12'h004, 32'h2, e);
        chk("w1c_err", 32'(e), 32'd0);
        apb_rd(12'h004, d); chk("w1c_clear", d, 32'h0);

        // ---------------- same operands, dot product; results kept
        run(1'b1, 1'b0, "dot_seq");
        check_outputs("dot_seq");
        apb_rd(12'h008, d); chk("dot_lit", d, 32'h5A);
        apb_rd(12'h000, d); chk("ctrl_rb", d, 32'h2);

        // ---------------- all 0xFF
        for (int i = 0; i < N; i++) begin ma[i] = 255; mb[i] = 255; end
        load_banks();
        run(1'b1, 1'b0, "dot_max");
        check_outputs("dot_max");
        apb_rd(12'h008, d); chk("dot_max_lit", d, 32'h0008_EE09);
        run(1'b0, 1'b0, "ew_max");
        check_outputs("ew_max");
        apb_rd(12'h310, d); chk("ew_max_lit", d, 32'hFE01);

        // ---------------- randomized runs
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                ma[i] = $urandom_range(0, 255);
                mb[i] = $urandom_range(0, 255);
            end
            m = 1'($urandom_range(0, 1));
            load_banks();
            run(m, 1'b0, $sformatf("rnd%0d", t));
            check_outputs($sformatf("rnd%0d", t));
        end

        // ---------------- writes rejected while busy
        for (int i = 0; i < N; i++) begin ma[i] = 3 * i + 1; mb[i] = 7; end
        load_banks();
        apb_wr(12'h000, 32'h1, e);
        model_run(1'b0);
        apb_wr(12'h100, 32'hDEAD_BEEF, e); chk("busy_wr_a_err",    32'(e), 32'd1);
        apb_wr(12'h000, 32'h3, e);         chk("busy_wr_ctrl_err", 32'(e), 32'd1);
        apb_wr(12'h204, 32'h1234_5678, e); chk("busy_wr_b_err",    32'(e), 32'd1);
        apb_rd(12'h100, d);                chk("busy_bank_a_kept", d, pack(1'b0, 0));
        begin
            int cyc;
            wait_idle(cyc);
        end
        check_outputs("busy_run");
        apb_rd(12'h000, d); chk("busy_ctrl_kept", d, 32'h0);
        apb_rd(12'h204, d); chk("busy_bank_b_kept", d, pack(1'b1, 1));

        // ---------------- W1C in the FINISH cycle: set wins
        apb_wr(12'h000, 32'h1, e);                 // START at edge T0
        repeat (N - 1) @(posedge HCLK);            // edge T(N-1)
        #1 PADDR = 12'h004; PWDATA = 32'h2; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge HCLK);
        #1 PENABLE = 1'b1;
        #1 chk("w1c_finish_err", 32'(PSLVERR), 32'd0);
        @(posedge HCLK);                           // edge T(N+1): FINISH
        #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        apb_rd(12'h004, d); chk("w1c_finish_set_wins", d, 32'h2);

`ifdef ACC_IRQ_EN
        // ---------------- interrupt
        run(1'b0, 1'b1, "irq");
        chk("irq_before", 32'(irq_o), 32'd0);
        @(negedge HCLK);
        chk("irq_rise", 32'(irq_o), 32'd1);
        apb_wr(12'h004, 32'h2, e);
        chk("irq_hold", 32'(irq_o), 32'd1);
        @(posedge HCLK);
        #1 chk("irq_fall", 32'(irq_o), 32'd0);
`endif

        // ---------------- HRESET mid-run
        for (int i = 0; i < N; i++) begin ma[i] = i + 5; mb[i] = i + 9; end
        load_banks();
        apb_wr(12'h000, 32'h1, e);
        repeat (4) @(posedge HCLK);
        #1 HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        foreach (ma[i]) begin ma[i] = 0; mb[i] = 0; mres[i] = 0; end
        mdot = 0;
        apb_rd(12'h004, d); chk("mid_rst_status", d, 32'h0);
        apb_rd(12'h000, d); chk("mid_rst_ctrl",   d, 32'h0);
        for (int i = 0; i < N; i++) begin
            apb_rd(12'(12'h300 + 4 * i), d); chk($sformatf("mid_rst_res%0d", i), d, 32'h0);
        end
        apb_rd(12'h008, d); chk("mid_rst_dot_lo", d, 32'h0);
        apb_rd(12'h00C, d); chk("mid_rst_dot_hi", d, 32'h0);
        apb_rd(12'h100, d); chk("mid_rst_bank_a", d, 32'h0);

        // ---------------- map boundaries
        apb_rd(12'h010, d); chk("unmapped_010", d, 32'hFFFF_FFFF);
        apb_rd(12'h400, d); chk("unmapped_400", d, 32'hFFFF_FFFF);
        apb_wr(12'h010, 32'h5, e); chk("unmapped_wr_err", 32'(e), 32'd0);
        apb_wr(12'(12'h100 + 4 * NW), 32'hFFFF_FFFF, e);
        chk("oob_word_wr_err", 32'(e), 32'd0);
        apb_rd(12'(12'h100 + 4 * NW), d); chk("oob_word_rd", d, 32'h0);
        apb_wr(12'(12'h100 + 4 * (NW - 1)), 32'hFFFF_FFFF, e);
        for (int i = (NW - 1) * E; i < N; i++) ma[i] = 255;
        apb_rd(12'(12'h100 + 4 * (NW - 1)), d); chk("partial_word", d, pack(1'b0, NW - 1));
        apb_rd(12'(12'h300 + 4 * N), d); chk("oob_result", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
